// File: rtl/i2d_core_defines.sv
// Shared i2d core definitions: register-address type, PC register index,
// pipeline-controller state encoding and exception causes.
package i2d_core_defines;

  typedef logic [3:0] reg_addr_t;

  localparam reg_addr_t RF_PC = 4'd15;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LU_STALL = 3'd1,
    MEM_WAIT = 3'd2,
    BR_FLUSH = 3'd3,
    EXC_WAIT = 3'd4
  } pctl_state_t;

  typedef enum logic [1:0] {
    EXC_SWI = 2'd0,
    EXC_ERR = 2'd1,
    EXC_IRQ = 2'd2
  } exc_cause_t;

  // Decode errors outrank software interrupts, which outrank external irqs.
  function automatic exc_cause_t exc_prio(input logic id_err, input logic swi);
    exc_cause_t c;
    if (id_err) begin
      c = EXC_ERR;
    end else if (swi) begin
      c = EXC_SWI;
    end else begin
      c = EXC_IRQ;
    end
    return c;
  endfunction

endpackage

// File: rtl/core_pipe_ctrl_hazard_det.sv
// Load-use comparator: flags an ID-stage source that depends on a load in EX.
import i2d_core_defines::*;

module core_hazard_det (
  input  reg_addr_t rega_addr,
  input  reg_addr_t regb_addr,
  input  logic      regb_used,
  input  logic      ex_load,
  input  reg_addr_t ex_wb_addr,
  output logic      lu_hazard
);

  logic a_match_s;
  logic b_match_s;

  assign a_match_s = (rega_addr == ex_wb_addr);
  assign b_match_s = regb_used && (regb_addr == ex_wb_addr);

  // Loads into the PC are redirects, resolved by the branch path instead.
  always_comb begin
    lu_hazard = 1'b0;
    if (ex_load && (ex_wb_addr != RF_PC)) begin
      lu_hazard = a_match_s || b_match_s;
    end else begin
      lu_hazard = 1'b0;
    end
  end

endmodule

// File: rtl/core_pipe_ctrl.sv
// Front-end pipeline sequencer: prioritises exceptions, branches, MAU waits
// and load-use hazards into halt/flush controls, plus a stall-cycle counter.
import i2d_core_defines::*;

module core_pipe_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  reg_addr_t        rega_addr,
  input  reg_addr_t        regb_addr,
  input  logic             regb_used,
  input  logic             ex_load,
  input  reg_addr_t        ex_wb_addr,
  input  logic             mau_busy,
  input  logic             mau_done,
  input  logic             branch,
  input  logic             swi,
  input  logic             id_err,
  input  logic             rfe,
  input  logic             irq,
  input  logic             irq_en,
  output logic             if_halt,
  output logic             id_halt,
  output logic             id_flush,
  output logic             ex_flush,
  output logic             exc_take,
  output logic [1:0]       exc_cause,
  output logic [CNT_W-1:0] stall_cnt
);

  pctl_state_t      state_r;
  pctl_state_t      state_nxt_s;
  exc_cause_t       cause_r;
  exc_cause_t       cause_nxt_s;
  exc_cause_t       req_cause_s;
  logic             lu_hazard_s;
  logic             exc_req_s;
  logic             mem_stall_s;
  logic [CNT_W-1:0] cnt_r;

  core_hazard_det u_hazard_det (
    .rega_addr  (rega_addr),
    .regb_addr  (regb_addr),
    .regb_used  (regb_used),
    .ex_load    (ex_load),
    .ex_wb_addr (ex_wb_addr),
    .lu_hazard  (lu_hazard_s)
  );

  assign exc_req_s   = swi || id_err || (irq && irq_en);
  assign req_cause_s = exc_prio(id_err, swi);
  // A completion arriving with the busy flag counts as an idle MAU.
  assign mem_stall_s = mau_busy && !mau_done;

  // Next-state and Mealy output decode.
  always_comb begin
    state_nxt_s = state_r;
    cause_nxt_s = cause_r;
    if_halt     = 1'b0;
    id_halt     = 1'b0;
    id_flush    = 1'b0;
    ex_flush    = 1'b0;
    exc_take    = 1'b0;
    exc_cause   = 2'b00;
    case (state_r)
      RUN: begin
        if (exc_req_s) begin
          if (mem_stall_s) begin
            if_halt     = 1'b1;
            id_halt     = 1'b1;
            cause_nxt_s = req_cause_s;
            state_nxt_s = EXC_WAIT;
          end else begin
            exc_take  = 1'b1;
            exc_cause = req_cause_s;
            id_flush  = 1'b1;
            ex_flush  = 1'b1;
          end
        end else if (branch || rfe) begin
          id_flush    = 1'b1;
          state_nxt_s = BR_FLUSH;
        end else if (mem_stall_s) begin
          if_halt     = 1'b1;
          id_halt     = 1'b1;
          state_nxt_s = MEM_WAIT;
        end else if (lu_hazard_s) begin
          if_halt     = 1'b1;
          id_halt     = 1'b1;
          ex_flush    = 1'b1;
          state_nxt_s = LU_STALL;
        end else begin
          state_nxt_s = RUN;
        end
      end
      LU_STALL: begin
        if_halt     = 1'b1;
        id_halt     = 1'b1;
        state_nxt_s = RUN;
      end
      MEM_WAIT: begin
        if (mau_done) begin
          state_nxt_s = RUN;
        end else begin
          if_halt = 1'b1;
          id_halt = 1'b1;
        end
      end
      BR_FLUSH: begin
        id_flush    = 1'b1;
        state_nxt_s = RUN;
      end
      EXC_WAIT: begin
        if (mau_done) begin
          exc_take    = 1'b1;
          exc_cause   = cause_r;
          id_flush    = 1'b1;
          ex_flush    = 1'b1;
          state_nxt_s = RUN;
        end else begin
          if_halt = 1'b1;
          id_halt = 1'b1;
        end
      end
      default: begin
        state_nxt_s = RUN;
        cause_nxt_s = EXC_SWI;
      end
    endcase
  end

  // State and latched exception cause.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= RUN;
      cause_r <= EXC_SWI;
    end else begin
      state_r <= state_nxt_s;
      cause_r <= cause_nxt_s;
    end
  end

  // Saturating count of fetch-halt cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (if_halt && (cnt_r != {CNT_W{1'b1}})) begin
      cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign stall_cnt = cnt_r;

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Scoreboard bench for core_pipe_ctrl: directed scenarios plus random traffic
// checked against a cycle-level model built from penalty counters.
`timescale 1ns/1ps
import i2d_core_defines::*;

module tb_core_pipe_ctrl;

  localparam int CNT_W = 16;

  typedef struct packed {
    logic      rst;
    reg_addr_t rega;
    reg_addr_t regb;
    logic      regb_used;
    logic      ex_load;
    reg_addr_t ex_wb;
    logic      mau_busy;
    logic      mau_done;
    logic      branch;
    logic      swi;
    logic      id_err;
    logic      rfe;
    logic      irq;
    logic      irq_en;
  } stim_t;

  typedef struct packed {
    logic             if_halt;
    logic             id_halt;
    logic             id_flush;
    logic             ex_flush;
    logic             exc_take;
    logic [1:0]       cause;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  reg_addr_t rega_addr, regb_addr, ex_wb_addr;
  logic regb_used, ex_load, mau_busy, mau_done, branch, swi, id_err, rfe, irq, irq_en;
  logic if_halt, id_halt, id_flush, ex_flush, exc_take;
  logic [1:0] exc_cause;
  logic [CNT_W-1:0] stall_cnt;

  always #5 clk = ~clk;

  core_pipe_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .rega_addr(rega_addr), .regb_addr(regb_addr),
    .regb_used(regb_used), .ex_load(ex_load), .ex_wb_addr(ex_wb_addr),
    .mau_busy(mau_busy), .mau_done(mau_done), .branch(branch), .swi(swi),
    .id_err(id_err), .rfe(rfe), .irq(irq), .irq_en(irq_en),
    .if_halt(if_halt), .id_halt(id_halt), .id_flush(id_flush), .ex_flush(ex_flush),
    .exc_take(exc_take), .exc_cause(exc_cause), .stall_cnt(stall_cnt)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  // Reference model: outstanding penalty cycles rather than controller states.
  int         m_flush_left;
  int         m_hold_left;
  bit         m_mem_wait;
  bit         m_exc_wait;
  logic [1:0] m_cause;
  int         m_cnt;

  task automatic model_reset();
    m_flush_left = 0; m_hold_left = 0; m_mem_wait = 0; m_exc_wait = 0;
    m_cause = 2'd0; m_cnt = 0;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit exc_req, lu;
    logic [1:0] cause;
    e = '0;
    e.cnt = CNT_W'(m_cnt);
    exc_req = s.swi || s.id_err || (s.irq && s.irq_en);
    cause = s.id_err ? 2'd1 : (s.swi ? 2'd0 : 2'd2);
    lu = s.ex_load && (s.ex_wb != 4'd15) &&
         ((s.rega == s.ex_wb) || (s.regb_used && (s.regb == s.ex_wb)));
    if (m_exc_wait) begin
      if (s.mau_done) begin
        e.exc_take = 1'b1; e.cause = m_cause; e.id_flush = 1'b1; e.ex_flush = 1'b1;
        m_exc_wait = 0;
      end else begin
        e.if_halt = 1'b1; e.id_halt = 1'b1;
      end
    end else if (m_mem_wait) begin
      if (s.mau_done) m_mem_wait = 0;
      else begin e.if_halt = 1'b1; e.id_halt = 1'b1; end
    end else if (m_flush_left > 0) begin
      e.id_flush = 1'b1; m_flush_left--;
    end else if (m_hold_left > 0) begin
      e.if_halt = 1'b1; e.id_halt = 1'b1; m_hold_left--;
    end else if (exc_req) begin
      if (s.mau_busy && !s.mau_done) begin
        e.if_halt = 1'b1; e.id_halt = 1'b1; m_exc_wait = 1; m_cause = cause;
      end else begin
        e.exc_take = 1'b1; e.cause = cause; e.id_flush = 1'b1; e.ex_flush = 1'b1;
      end
    end else if (s.branch || s.rfe) begin
      e.id_flush = 1'b1; m_flush_left = 1;
    end else if (s.mau_busy && !s.mau_done) begin
      e.if_halt = 1'b1; e.id_halt = 1'b1; m_mem_wait = 1;
    end else if (lu) begin
      e.if_halt = 1'b1; e.id_halt = 1'b1; e.ex_flush = 1'b1; m_hold_left = 1;
    end
    if (e.if_halt && m_cnt < (2**CNT_W - 1)) m_cnt++;
  endtask

  // One clock of stimulus; the expected response goes to the scoreboard.
  task automatic drive(input stim_t s, input bit chk);
    exp_t e;
    @(posedge clk);
    #1;
    rst = s.rst; rega_addr = s.rega; regb_addr = s.regb; regb_used = s.regb_used;
    ex_load = s.ex_load; ex_wb_addr = s.ex_wb; mau_busy = s.mau_busy;
    mau_done = s.mau_done; branch = s.branch; swi = s.swi; id_err = s.id_err;
    rfe = s.rfe; irq = s.irq; irq_en = s.irq_en;
    cyc++;
    if (s.rst) begin
      model_reset();
    end else begin
      model_step(s, e);
      if (chk) exp_q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    stim_t s;
    s = '0;
    for (int i = 0; i < n; i++) drive(s, 1'b1);
  endtask

  // Monitor: every checked cycle the DUT presents its outputs mid-cycle.
  always @(negedge clk) begin
    exp_t e, a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {if_halt, id_halt, id_flush, ex_flush, exc_take, exc_cause, stall_cnt};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL outputs cyc=%0d act ih=%b dh=%b df=%b xf=%b tk=%b c=%0d cnt=%0d exp ih=%b dh=%b df=%b xf=%b tk=%b c=%0d cnt=%0d",
                 cyc, a.if_halt, a.id_halt, a.id_flush, a.ex_flush, a.exc_take, a.cause, a.cnt,
                 e.if_halt, e.id_halt, e.id_flush, e.ex_flush, e.exc_take, e.cause, e.cnt);
      end
    end
  end

  initial begin
    stim_t s;
    int n;
    rst = 1'b1; rega_addr = 4'd0; regb_addr = 4'd0; ex_wb_addr = 4'd0;
    regb_used = 1'b0; ex_load = 1'b0; mau_busy = 1'b0; mau_done = 1'b0;
    branch = 1'b0; swi = 1'b0; id_err = 1'b0; rfe = 1'b0; irq = 1'b0; irq_en = 1'b0;
    model_reset();

    s = '0; s.rst = 1'b1;
    drive(s, 1'b0); drive(s, 1'b0);
    idle(10);

    // Load-use on source A, then source B as immediate, then a PC destination.
    s = '0; s.ex_load = 1'b1; s.ex_wb = 4'd3; s.rega = 4'd3;
    drive(s, 1'b1); idle(3);
    s = '0; s.ex_load = 1'b1; s.ex_wb = 4'd3; s.rega = 4'd5; s.regb = 4'd3;
    drive(s, 1'b1); idle(2);
    s.regb_used = 1'b1;
    drive(s, 1'b1); idle(3);
    s = '0; s.ex_load = 1'b1; s.ex_wb = 4'd15; s.rega = 4'd15;
    drive(s, 1'b1); idle(2);

    s = '0; s.branch = 1'b1;
    drive(s, 1'b1); idle(3);
    s = '0; s.rfe = 1'b1;
    drive(s, 1'b1); idle(3);

    s = '0; s.mau_busy = 1'b1;
    for (int i = 0; i < 5; i++) drive(s, 1'b1);
    s.mau_done = 1'b1; drive(s, 1'b1); idle(2);

    // Exception held behind the MAU, then the masked-irq variant.
    s = '0; s.mau_busy = 1'b1; s.swi = 1'b1;
    drive(s, 1'b1); s.swi = 1'b0; s.irq = 1'b1;
    drive(s, 1'b1); drive(s, 1'b1);
    s.irq = 1'b0; s.mau_done = 1'b1; drive(s, 1'b1); idle(2);
    s = '0; s.mau_busy = 1'b1; s.irq = 1'b1;
    for (int i = 0; i < 3; i++) drive(s, 1'b1);
    s.mau_done = 1'b1; drive(s, 1'b1); idle(2);

    // Direct exceptions with cause priority, and exception during branch flush.
    s = '0; s.irq = 1'b1; s.irq_en = 1'b1; drive(s, 1'b1);
    s.swi = 1'b1; drive(s, 1'b1);
    s.id_err = 1'b1; drive(s, 1'b1); idle(1);
    s = '0; s.branch = 1'b1; drive(s, 1'b1);
    s = '0; s.swi = 1'b1; drive(s, 1'b1); drive(s, 1'b1); idle(2);

    for (int i = 0; i < 1500; i++) begin
      s = '0;
      s.rst       = ($urandom_range(0, 199) == 0);
      s.rega      = reg_addr_t'($urandom_range(0, 3));
      s.regb      = reg_addr_t'($urandom_range(0, 3));
      s.regb_used = $urandom_range(0, 1);
      s.ex_load   = ($urandom_range(0, 2) == 0);
      s.ex_wb     = ($urandom_range(0, 7) == 0) ? 4'd15 : reg_addr_t'($urandom_range(0, 3));
      s.mau_busy  = ($urandom_range(0, 3) == 0);
      s.mau_done  = ($urandom_range(0, 4) == 0);
      s.branch    = ($urandom_range(0, 9) == 0);
      s.rfe       = ($urandom_range(0, 19) == 0);
      s.swi       = ($urandom_range(0, 19) == 0);
      s.id_err    = ($urandom_range(0, 29) == 0);
      s.irq       = ($urandom_range(0, 9) == 0);
      s.irq_en    = $urandom_range(0, 1);
      drive(s, 1'b1);
    end
    idle(4);

    // Long MAU wait to saturate the counter, then reset while still waiting.
    s = '0; s.mau_busy = 1'b1;
    n = 2**CNT_W + 5;
    for (int i = 0; i < n; i++) drive(s, (i < 3) || (i > n - 8));
    s = '0; s.rst = 1'b1; drive(s, 1'b0);
    idle(3);

    n = 0;
    while (exp_q.size() > 0 && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain act=%0d pending required=0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
